puerta_secuenciador: RTL and testbench
======================================

Name: puerta_secuenciador

Overview:
Timed Moore controller for the automatic door motor. It sequences the door through open-travel, hold, close-travel and lockout phases using a tick prescaler off the 50 MHz clock. It counts obstacle-triggered reversals and raises the alarm after too many. It sits between the presence/obstacle sensors and the motor driver (motor code 00 stop, 01 open, 10 close).

Parameters:
TICK_DIV, 50000000, clk cycles per tick (1 Hz at 50 MHz); must be ≥2
OPEN_TICKS, 3, ticks of motor=01 for full opening; ≥1
HOLD_TICKS, 5, ticks the door stays open after the last sense/obs activity; ≥1
CLOSE_TICKS, 3, ticks of motor=10 for full closing; ≥1
MAX_RETRIES, 3, obstacle reversals in one cycle before lockout; ≥1

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-low reset (0 = reset)
sense  in  1  presence sensor, active high
obs  in  1  obstacle sensor, active high
ack  in  1  operator acknowledge; clears lockout
motor  out  2  00 stop, 01 open, 10 close
alarm  out  1  high while in lockout
estado  out  3  current state code, for debug/LEDs
led_tick  out  1  toggles on every tick

Behaviour:
- Reset (rst=0, async): state CERRADO, prescaler=0, timer=0, retries=0, led_tick=0, motor=00, alarm=0, estado=000.
- Prescaler: free-running 0..TICK_DIV-1. tick is a 1-cycle internal pulse when the prescaler wraps. The first tick comes TICK_DIV cycles after reset release. led_tick toggles on each tick.
- Timer: loaded with N on entry to a timed state. It decrements on tick. The timed transition fires on the clk edge where tick=1 and timer=1, so a phase lasts exactly N ticks after a tick-aligned entry and N-1 ticks plus a partial tick otherwise.
- sense, obs and ack are sampled every clk edge, not per tick. Inputs are synchronous to clk unless the optional feature is enabled.
- motor, alarm and estado are decoded from the state register only (Moore). They change on the same edge as the state, with no extra latency.
- States (estado code, motor, alarm):
  CERRADO (000, 00, 0): sense=1 -> ABRIENDO, load OPEN_TICKS. obs alone is ignored.
  ABRIENDO (001, 01, 0): expiry -> ABIERTO, load HOLD_TICKS. Sensors are ignored during opening.
  ABIERTO (010, 00, 0): sense=1 or obs=1 reloads HOLD_TICKS every cycle it is high. Expiry with both low -> CERRANDO, load CLOSE_TICKS.
  CERRANDO (011, 10, 0): priority obs > sense > expiry.
   - obs=1: retries+1. If the new value equals MAX_RETRIES -> BLOQUEO, else -> ABRIENDO with load OPEN_TICKS.
   - sense=1 (obs=0): -> ABRIENDO, load OPEN_TICKS, retries unchanged.
   - expiry: -> CERRADO, retries cleared to 0.
  BLOQUEO (100, 00, 1): timer idle. ack=1 and obs=0 -> ABIERTO, load HOLD_TICKS, retries cleared. ack with obs=1 is ignored.
- Simultaneous events: an obs/sense condition and expiry on the same edge take the sensor branch. In ABIERTO, activity and expiry on the same edge reload the timer; the door does not close.
- Unused codes 101–111 -> CERRADO next edge with motor=00.
- Widths: timer width is $clog2(max(OPEN,HOLD,CLOSE)+1). Retry width is $clog2(MAX_RETRIES+1). The retry counter saturates and never wraps.
- Reset mid-motion forces CERRADO and motor=00 immediately (asynchronous), regardless of state.

Optional Feature:
PUERTA_DEBOUNCE_EN:
- Defined: sense, obs and ack each pass through a 2-FF synchronizer, then a stability filter. The filtered value updates only after the raw value has been constant for 4 consecutive clk cycles. This adds 6 cycles of latency on every input edge, and pulses of 3 cycles or less are rejected.
- Undefined: inputs are used directly, with 0 cycles of added latency.

Test Plan:
(TICK_DIV=4, OPEN_TICKS=3, HOLD_TICKS=5, CLOSE_TICKS=3, MAX_RETRIES=2, debounce off)
1. Reset held low, then released with sense=obs=0 -> motor=00, alarm=0, estado=000 forever. led_tick first toggles 4 cycles after release.
2. Pulse sense high for 1 cycle from CERRADO -> expected sequence:
   - motor=01 for 3 ticks;
   - estado=010, motor=00 for 5 ticks;
   - motor=10 for 3 ticks;
   - estado=000.
3. Assert obs for 1 cycle while in CERRANDO -> same edge: estado=001, motor=01, alarm=0. After the open and hold phases the door closes normally and retries return to 0.
4. Assert obs in CERRANDO twice within one cycle -> second obs gives estado=100, motor=00, alarm=1. Pulse ack with obs=1 -> no change. Pulse ack with obs=0 -> estado=010, alarm=0.
5. Hold sense high in ABIERTO for 20 ticks, then drop it -> motor stays 00 throughout. Closing starts exactly 5 ticks after sense falls.
6. Drive rst low mid-CERRANDO -> motor=00, estado=000 asynchronously, before the next clk edge. After release, retries=0.

Source files
------------

// File: rtl/puerta_secuenciador.sv
`default_nettype none
// ============================================================================
// Module      : puerta_secuenciador
// Description : Timed Moore controller for an automatic door motor.
//               It sequences the door through the open, hold, close and
//               lockout phases on a prescaled tick. It counts obstacle
//               reversals and locks out after MAX_RETRIES of them.
//               Motor codes: 00 stop, 01 open, 10 close.
//               Optional macro PUERTA_DEBOUNCE_EN: when defined, each input
//               goes through a 2-FF synchronizer followed by a
//               4-cycle stability filter.
// Revision    : 1.0 - initial release
// ============================================================================
module puerta_secuenciador #(
    parameter int TICK_DIV    = 50000000,
    parameter int OPEN_TICKS  = 3,
    parameter int HOLD_TICKS  = 5,
    parameter int CLOSE_TICKS = 3,
    parameter int MAX_RETRIES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sense,
    input  logic       obs,
    input  logic       ack,
    output logic [1:0] motor,
    output logic       alarm,
    output logic [2:0] estado,
    output logic       led_tick
);

    // ------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------
    localparam int c_MAX_OC = (OPEN_TICKS > CLOSE_TICKS) ? OPEN_TICKS : CLOSE_TICKS;
    localparam int c_MAX_T  = (c_MAX_OC > HOLD_TICKS) ? c_MAX_OC : HOLD_TICKS;
    localparam int c_TW     = $clog2(c_MAX_T + 1);
    localparam int c_RW     = $clog2(MAX_RETRIES + 1);
    localparam int c_PW     = $clog2(TICK_DIV);

    localparam logic [c_TW-1:0] c_OPEN  = c_TW'(OPEN_TICKS);
    localparam logic [c_TW-1:0] c_HOLD  = c_TW'(HOLD_TICKS);
    localparam logic [c_TW-1:0] c_CLOSE = c_TW'(CLOSE_TICKS);
    localparam logic [c_RW-1:0] c_RMAX  = c_RW'(MAX_RETRIES);
    localparam logic [c_PW-1:0] c_PLAST = c_PW'(TICK_DIV - 1);

    localparam logic [2:0] c_CERRADO  = 3'b000;
    localparam logic [2:0] c_ABRIENDO = 3'b001;
    localparam logic [2:0] c_ABIERTO  = 3'b010;
    localparam logic [2:0] c_CERRANDO = 3'b011;
    localparam logic [2:0] c_BLOQUEO  = 3'b100;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic w_sense;
    logic w_obs;
    logic w_ack;

`ifdef PUERTA_DEBOUNCE_EN
    // Bit order in every vector below: {ack, obs, sense}
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] r_h0;
    logic [2:0] r_h1;
    logic [2:0] r_h2;
    logic [2:0] r_filt;
    logic [2:0] w_all1;
    logic [2:0] w_all0;

    // The filtered value flips only when the synchronized value and its
    // three predecessors agree, so pulses of 3 cycles or less never pass.
    assign w_all1 = r_sync2 & r_h0 & r_h1 & r_h2;
    assign w_all0 = ~(r_sync2 | r_h0 | r_h1 | r_h2);

    // Synchronizer, history shift register and filtered output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_h0    <= '0;
            r_h1    <= '0;
            r_h2    <= '0;
            r_filt  <= '0;
        end else begin
            r_sync1 <= {ack, obs, sense};
            r_sync2 <= r_sync1;
            r_h0    <= r_sync2;
            r_h1    <= r_h0;
            r_h2    <= r_h1;
            r_filt  <= (r_filt | w_all1) & ~w_all0;
        end
    end

    assign w_sense = r_filt[0];
    assign w_obs   = r_filt[1];
    assign w_ack   = r_filt[2];
`else
    assign w_sense = sense;
    assign w_obs   = obs;
    assign w_ack   = ack;
`endif

    // ------------------------------------------------------------------
    // Tick prescaler
    // ------------------------------------------------------------------
    logic [c_PW-1:0] r_presc;
    logic            r_led;
    logic            w_tick;

    assign w_tick = (r_presc == c_PLAST);

    // Free-running prescaler. The LED toggles on every wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_led   <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
            if (w_tick) begin
                r_led <= ~r_led;
            end
        end
    end

    assign led_tick = r_led;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [c_TW-1:0] r_timer;
    logic [c_TW-1:0] w_timer_nxt;
    logic [c_RW-1:0] r_retries;
    logic [c_RW-1:0] w_retries_nxt;
    logic [c_RW-1:0] w_retry_inc;
    logic            w_expiry;

    // A phase ends on the tick edge where the timer holds its last count.
    assign w_expiry    = w_tick && (r_timer == c_TW'(1));
    // The retry count saturates at the limit and never wraps.
    assign w_retry_inc = (r_retries == c_RMAX) ? r_retries : r_retries + c_RW'(1);

    // Next-state, timer and retry logic. Sensor branches take priority over expiry.
    always_comb begin
        w_state_nxt   = r_state;
        w_retries_nxt = r_retries;
        w_timer_nxt   = r_timer;
        if (w_tick && (r_timer != '0)) begin
            w_timer_nxt = r_timer - c_TW'(1);
        end

        case (r_state)
            c_CERRADO: begin
                if (w_sense) begin
                    w_state_nxt = c_ABRIENDO;
                    w_timer_nxt = c_OPEN;
                end
            end
            c_ABRIENDO: begin
                if (w_expiry) begin
                    w_state_nxt = c_ABIERTO;
                    w_timer_nxt = c_HOLD;
                end
            end
            c_ABIERTO: begin
                if (w_sense || w_obs) begin
                    w_timer_nxt = c_HOLD;
                end else if (w_expiry) begin
                    w_state_nxt = c_CERRANDO;
                    w_timer_nxt = c_CLOSE;
                end
            end
            c_CERRANDO: begin
                if (w_obs) begin
                    w_retries_nxt = w_retry_inc;
                    if (w_retry_inc == c_RMAX) begin
                        w_state_nxt = c_BLOQUEO;
                        w_timer_nxt = '0;
                    end else begin
                        w_state_nxt = c_ABRIENDO;
                        w_timer_nxt = c_OPEN;
                    end
                end else if (w_sense) begin
                    w_state_nxt = c_ABRIENDO;
                    w_timer_nxt = c_OPEN;
                end else if (w_expiry) begin
                    w_state_nxt   = c_CERRADO;
                    w_retries_nxt = '0;
                end
            end
            c_BLOQUEO: begin
                w_timer_nxt = '0;
                if (w_ack && !w_obs) begin
                    w_state_nxt   = c_ABIERTO;
                    w_timer_nxt   = c_HOLD;
                    w_retries_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = c_CERRADO;
                w_timer_nxt = '0;
            end
        endcase
    end

    // State, timer and retry registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_CERRADO;
            r_timer   <= '0;
            r_retries <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_retries <= w_retries_nxt;
        end
    end

    // Moore output decode, taken from the state register only
    always_comb begin
        motor  = 2'b00;
        alarm  = 1'b0;
        estado = r_state;
        case (r_state)
            c_ABRIENDO: motor = 2'b01;
            c_CERRANDO: motor = 2'b10;
            c_BLOQUEO:  alarm = 1'b1;
            default:    motor = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_puerta_secuenciador.sv
`default_nettype none
// ============================================================================
// Module      : tb_puerta_secuenciador
// Description : Directed self-checking bench for puerta_secuenciador.
//               It uses TICK_DIV=4, OPEN=3, HOLD=5, CLOSE=3 and MAX_RETRIES=2.
//               cyc counts the clk edges since reset release. A tick falls
//               on every edge where cyc is a multiple of 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_puerta_secuenciador;

    logic       clk;
    logic       rst;
    logic       sense;
    logic       obs;
    logic       ack;
    logic [1:0] motor;
    logic       alarm;
    logic [2:0] estado;
    logic       led_tick;

    int n_cmp;
    int n_bad;
    int cyc;

    puerta_secuenciador #(
        .TICK_DIV    (4),
        .OPEN_TICKS  (3),
        .HOLD_TICKS  (5),
        .CLOSE_TICKS (3),
        .MAX_RETRIES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sense    (sense),
        .obs      (obs),
        .ack      (ack),
        .motor    (motor),
        .alarm    (alarm),
        .estado   (estado),
        .led_tick (led_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter since reset release
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d (cyc=%0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to the falling edge that follows rising edge number k
    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        sense = 1'b0;
        obs   = 1'b0;
        ack   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_estado", 32'(estado), 0);
        chk("rst_motor", 32'(motor), 0);
        chk("rst_alarm", 32'(alarm), 0);
        chk("rst_led", 32'(led_tick), 0);
        rst = 1'b1;

        // Idle behaviour and the first tick
        wait_cyc(3);  chk("led_pre", 32'(led_tick), 0); chk("idle_estado", 32'(estado), 0);
        wait_cyc(4);  chk("led_first", 32'(led_tick), 1); chk("idle_motor", 32'(motor), 0);
        chk("idle_alarm", 32'(alarm), 0);

        // Full cycle from a 1-cycle sense pulse
        sense = 1'b1; wait_cyc(5); sense = 1'b0;
        chk("open_estado", 32'(estado), 1); chk("open_motor", 32'(motor), 1);
        wait_cyc(15); chk("open_end", 32'(estado), 1);
        wait_cyc(16); chk("hold_estado", 32'(estado), 2); chk("hold_motor", 32'(motor), 0);
        wait_cyc(35); chk("hold_end", 32'(estado), 2);
        wait_cyc(36); chk("close_estado", 32'(estado), 3); chk("close_motor", 32'(motor), 2);
        wait_cyc(47); chk("close_end", 32'(estado), 3);
        wait_cyc(48); chk("closed_estado", 32'(estado), 0); chk("closed_motor", 32'(motor), 0);

        // Single obstacle reversal, followed by a normal close
        sense = 1'b1; wait_cyc(49); sense = 1'b0;
        chk("t3_open", 32'(estado), 1);
        wait_cyc(80); chk("t3_closing", 32'(estado), 3);
        wait_cyc(81); obs = 1'b1; wait_cyc(82); obs = 1'b0;
        chk("t3_rev_estado", 32'(estado), 1); chk("t3_rev_motor", 32'(motor), 1);
        chk("t3_rev_alarm", 32'(alarm), 0);
        wait_cyc(92);  chk("t3_hold", 32'(estado), 2);
        wait_cyc(112); chk("t3_close", 32'(estado), 3);
        wait_cyc(124); chk("t3_closed", 32'(estado), 0);

        // Two reversals in one cycle lead to lockout; ack with obs high is ignored
        sense = 1'b1; wait_cyc(125); sense = 1'b0;
        wait_cyc(156); chk("t4_closing1", 32'(estado), 3);
        obs = 1'b1; wait_cyc(157); obs = 1'b0;
        chk("t4_rev1", 32'(estado), 1);
        wait_cyc(188); chk("t4_closing2", 32'(estado), 3);
        obs = 1'b1; wait_cyc(189); obs = 1'b0;
        chk("t4_lock_estado", 32'(estado), 4); chk("t4_lock_motor", 32'(motor), 0);
        chk("t4_lock_alarm", 32'(alarm), 1);
        wait_cyc(190); ack = 1'b1; obs = 1'b1; wait_cyc(191); ack = 1'b0; obs = 1'b0;
        chk("t4_ack_obs", 32'(estado), 4); chk("t4_ack_obs_alarm", 32'(alarm), 1);
        wait_cyc(196); chk("t4_still_lock", 32'(estado), 4);
        ack = 1'b1; wait_cyc(197); ack = 1'b0;
        chk("t4_unlock_estado", 32'(estado), 2); chk("t4_unlock_alarm", 32'(alarm), 0);
        chk("t4_unlock_motor", 32'(motor), 0);

        // Presence held for 20 ticks keeps the door open
        sense = 1'b1;
        for (int k = 201; k <= 277; k += 4) begin
            wait_cyc(k);
            chk("t5_hold_motor", 32'(motor), 0);
            chk("t5_hold_estado", 32'(estado), 2);
        end
        sense = 1'b0;
        wait_cyc(295); chk("t5_last_hold", 32'(estado), 2);
        wait_cyc(296); chk("t5_close_estado", 32'(estado), 3); chk("t5_close_motor", 32'(motor), 2);

        // Leave one retry pending, then reset mid-closing
        obs = 1'b1; wait_cyc(297); obs = 1'b0;
        chk("t6_rev", 32'(estado), 1);
        wait_cyc(308); chk("t6_hold", 32'(estado), 2);
        wait_cyc(328); chk("t6_closing", 32'(estado), 3);
        wait_cyc(329);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_estado", 32'(estado), 0);
        chk("t6_async_motor", 32'(motor), 0);
        chk("t6_async_alarm", 32'(alarm), 0);
        chk("t6_async_led", 32'(led_tick), 0);
        @(negedge clk);
        rst = 1'b1; sense = 1'b1;
        wait_cyc(1); sense = 1'b0;
        chk("t6_reopen", 32'(estado), 1);
        wait_cyc(3);  chk("t6_led_pre", 32'(led_tick), 0);
        wait_cyc(4);  chk("t6_led_first", 32'(led_tick), 1);
        wait_cyc(12); chk("t6_hold2", 32'(estado), 2);
        wait_cyc(32); chk("t6_closing2", 32'(estado), 3);
        obs = 1'b1; wait_cyc(33); obs = 1'b0;
        chk("t6_retry_cleared", 32'(estado), 1);
        chk("t6_retry_alarm", 32'(alarm), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
